// File: rtl/dmem_access_unit_if.sv
// Word-aligned data-memory bus: request side (req/we/addr/be/wdata) and
// response side (gnt/rvalid/rdata/err).
interface dmem_access_unit_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  logic            err;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store responder: turns one pipeline memory access into a single bus
// transaction, lane-shifts store data and extends load data.
module dmem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [3:0]      i_d_size,
  input  logic            i_d_unsigned,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_stall,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_rdata_valid,
  output logic            o_misaligned,
  output logic            o_bus_err,
  dmem_access_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_addr;
  logic [3:0]        r_be;
  logic [XLEN-1:0]   r_wdata;
  logic              r_we;
  logic [1:0]        r_off;
  logic [3:0]        r_size;
  logic              r_uns;
  logic              r_err;
  logic [XLEN-1:0]   r_rdata;

  logic w_request;
  logic w_legal;
  logic w_accept;
  logic w_rsp;
  logic w_tmo;
  logic w_cnt_end;

  function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] word,
                                               input logic [1:0]      off,
                                               input logic [3:0]      size,
                                               input logic            uns);
    logic [XLEN-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      4'b0001: f_extend = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      4'b0011: f_extend = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      default: f_extend = sh;
    endcase
  endfunction

  always_comb begin
    w_request = i_mem_read | i_mem_write;
    w_legal   = (i_d_size == 4'b0001) ||
                ((i_d_size == 4'b0011) && !i_addr[0]) ||
                ((i_d_size == 4'b1111) && (i_addr[1:0] == 2'b00));
    w_cnt_end = (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_rsp    = 1'b0;
    w_tmo    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_request && w_legal) begin
          w_accept = 1'b1;
          w_next   = S_REQ;
        end
      end
      // A response that coincides with the grant skips WAIT entirely
      S_REQ: begin
        if (bus.gnt && bus.rvalid) begin
          w_rsp  = 1'b1;
          w_next = S_RESP;
        end else if (w_cnt_end) begin
          w_tmo  = 1'b1;
          w_next = S_RESP;
        end else if (bus.gnt) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.rvalid) begin
          w_rsp  = 1'b1;
          w_next = S_RESP;
        end else if (w_cnt_end) begin
          w_tmo  = 1'b1;
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_off   <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= '0;
        r_addr  <= {i_addr[XLEN-1:2], 2'b00};
        r_be    <= i_d_size << i_addr[1:0];
        r_wdata <= i_wdata << {i_addr[1:0], 3'b000};
        r_we    <= i_mem_write;
        r_off   <= i_addr[1:0];
        r_size  <= i_d_size;
        r_uns   <= i_d_unsigned;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Stores never disturb the last load result
      if (w_rsp) begin
        r_err <= bus.err;
        if (!r_we) r_rdata <= bus.err ? '0 : f_extend(bus.rdata, r_off, r_size, r_uns);
      end else if (w_tmo) begin
        r_err <= 1'b1;
        if (!r_we) r_rdata <= '0;
      end
    end
  end

  // Request-driven outputs are gated by reset so an aborted access releases the pipeline at once
  always_comb begin
    o_stall       = i_rst_n & (w_accept || (r_state == S_REQ) || (r_state == S_WAIT));
    o_misaligned  = i_rst_n & (r_state == S_IDLE) & w_request & ~w_legal;
    o_rdata_valid = (r_state == S_RESP);
    o_bus_err     = (r_state == S_RESP) & r_err;
    o_rdata       = r_rdata;
    bus.req       = (r_state == S_REQ);
    bus.we        = r_we;
    bus.addr      = r_addr;
    bus.be        = r_be;
    bus.wdata     = r_wdata;
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: stimulus pushes expected responses,
// a negedge monitor pops and compares them against completed accesses.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, d_unsigned;
  logic [3:0]  d_size;
  logic [31:0] addr, wdata;
  logic        o_stall, o_rdata_valid, o_misaligned, o_bus_err;
  logic [31:0] o_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mis;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  dmem_access_unit_if #(.XLEN(32)) bus ();

  dmem_access_unit #(.XLEN(32), .TIMEOUT(255)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_mem_read    (mem_read),
    .i_mem_write   (mem_write),
    .i_d_size      (d_size),
    .i_d_unsigned  (d_unsigned),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .o_stall       (o_stall),
    .o_rdata       (o_rdata),
    .o_rdata_valid (o_rdata_valid),
    .o_misaligned  (o_misaligned),
    .o_bus_err     (o_bus_err),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completion or rejection must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (o_rdata_valid || o_misaligned) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: valid=%b mis=%b rdata=%h with nothing outstanding",
                 o_rdata_valid, o_misaligned, o_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp_misaligned", 32'(o_misaligned), 32'(mon_e.mis));
        chk("resp_valid", 32'(o_rdata_valid), 32'(!mon_e.mis));
        if (!mon_e.mis) begin
          chk("resp_rdata", o_rdata, mon_e.rdata);
          chk("resp_bus_err", 32'(o_bus_err), 32'(mon_e.err));
        end
      end
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [3:0] size, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gnt_dly, input int rv_dly,
                           input logic [31:0] rdata, input logic berr,
                           input logic [31:0] e_baddr, input logic [3:0] e_be,
                           input logic [31:0] e_bwdata, input logic [31:0] e_rdata,
                           input logic e_err, input string tag);
    exp_t e;
    e.mis = 1'b0; e.rdata = e_rdata; e.err = e_err;
    sb_q.push_back(e);
    mem_read = rd; mem_write = wr; d_size = size; d_unsigned = uns; addr = a; wdata = wd;
    @(negedge clk);
    chk({tag, "_stall_accept"}, 32'(o_stall), 32'd1);
    chk({tag, "_req_accept"}, 32'(bus.req), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i <= gnt_dly; i++) begin
      bus.gnt = (i == gnt_dly);
      if (i == gnt_dly && rv_dly == 0) begin
        bus.rvalid = 1'b1; bus.rdata = rdata; bus.err = berr;
      end
      @(negedge clk);
      chk({tag, "_req"}, 32'(bus.req), 32'd1);
      chk({tag, "_addr"}, bus.addr, e_baddr);
      chk({tag, "_be"}, 32'(bus.be), 32'(e_be));
      chk({tag, "_wdata"}, bus.wdata, e_bwdata);
      chk({tag, "_we"}, 32'(bus.we), 32'(wr));
      chk({tag, "_stall_req"}, 32'(o_stall), 32'd1);
      @(posedge clk); #1;
      bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.err = 1'b0;
    end
    for (int i = 1; i <= rv_dly; i++) begin
      if (i == rv_dly) begin
        bus.rvalid = 1'b1; bus.rdata = rdata; bus.err = berr;
      end
      @(negedge clk);
      chk({tag, "_req_wait"}, 32'(bus.req), 32'd0);
      chk({tag, "_stall_wait"}, 32'(o_stall), 32'd1);
      @(posedge clk); #1;
      bus.rvalid = 1'b0; bus.err = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_stall_resp"}, 32'(o_stall), 32'd0);
    chk({tag, "_valid_resp"}, 32'(o_rdata_valid), 32'd1);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_mis(input logic rd, input logic wr, input logic [3:0] size,
                        input logic [31:0] a, input string tag);
    exp_t e;
    e.mis = 1'b1; e.rdata = '0; e.err = 1'b0;
    sb_q.push_back(e);
    mem_read = rd; mem_write = wr; d_size = size; d_unsigned = 1'b0; addr = a;
    @(negedge clk);
    chk({tag, "_stall"}, 32'(o_stall), 32'd0);
    chk({tag, "_req"}, 32'(bus.req), 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk({tag, "_req_after"}, 32'(bus.req), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_req;
    int   n_val;
    logic done;
    exp_t e;

    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; d_size = 4'b0000; d_unsigned = 1'b0;
    addr = '0; wdata = '0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_valid", 32'(o_rdata_valid), 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    chk("rst_bus_err", 32'(o_bus_err), 32'd0);
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_be", 32'(bus.be), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // rd wr size uns addr wdata gdly rdly rdata berr | baddr be bwdata | rdata err
    do_access(1, 0, 4'b0001, 0, 32'h103, 32'h0, 0, 0, 32'h80FF_1234, 0,
              32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 0, "lb");
    do_access(1, 0, 4'b0001, 1, 32'h103, 32'h0, 1, 2, 32'h80FF_1234, 0,
              32'h100, 4'b1000, 32'h0, 32'h0000_0080, 0, "lbu");
    do_access(0, 1, 4'b0011, 0, 32'h202, 32'h0000_BEEF, 2, 1, 32'hFFFF_FFFF, 0,
              32'h200, 4'b1100, 32'hBEEF_0000, 32'h0000_0080, 0, "sh");
    do_access(1, 1, 4'b1111, 0, 32'h020, 32'h1122_3344, 0, 1, 32'hFFFF_FFFF, 0,
              32'h020, 4'b1111, 32'h1122_3344, 32'h0000_0080, 0, "rw_both");
    do_mis(1, 0, 4'b1111, 32'h301, "mis_lw");
    do_mis(1, 0, 4'b0111, 32'h300, "mis_size");
    do_mis(0, 1, 4'b0011, 32'h101, "mis_sh");
    do_access(1, 0, 4'b0011, 0, 32'h302, 32'h0, 5, 3, 32'h8001_0000, 0,
              32'h300, 4'b1100, 32'h0, 32'hFFFF_8001, 0, "lh_slow");
    do_access(1, 0, 4'b1111, 0, 32'h304, 32'h0, 0, 1, 32'hDEAD_BEEF, 0,
              32'h304, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, "lw");
    do_access(1, 0, 4'b0011, 1, 32'h102, 32'h0, 0, 0, 32'h8001_0000, 0,
              32'h100, 4'b1100, 32'h0, 32'h0000_8001, 0, "lhu");
    do_access(1, 0, 4'b1111, 0, 32'h500, 32'h0, 0, 2, 32'h1234_5678, 1,
              32'h500, 4'b1111, 32'h0, 32'h0000_0000, 1, "lw_err");
    do_access(0, 1, 4'b1111, 0, 32'h600, 32'hCAFE_F00D, 1, 0, 32'hFFFF_FFFF, 1,
              32'h600, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 1, "sw_err");
    do_access(1, 0, 4'b1111, 0, 32'h010, 32'h0, 0, 0, 32'h0102_0304, 0,
              32'h010, 4'b1111, 32'h0, 32'h0102_0304, 0, "lw_pre_tmo");

    // No grant at all: the access must abort after TIMEOUT request cycles
    e.mis = 1'b0; e.rdata = 32'h0; e.err = 1'b1;
    sb_q.push_back(e);
    mem_read = 1'b1; d_size = 4'b0001; d_unsigned = 1'b0; addr = 32'h701;
    @(posedge clk); #1;
    n_req = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.req) n_req++;
      if (o_rdata_valid) done = 1'b1;
    end
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_req_cycles", 32'(n_req), 32'd255);
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("tmo_idle_stall", 32'(o_stall), 32'd0);
    chk("tmo_idle_req", 32'(bus.req), 32'd0);
    @(posedge clk); #1;

    do_access(1, 0, 4'b1111, 0, 32'h010, 32'h0, 0, 0, 32'h0102_0304, 0,
              32'h010, 4'b1111, 32'h0, 32'h0102_0304, 0, "lw_post_tmo");

    // Reset while waiting for the response
    mem_read = 1'b1; d_size = 4'b1111; addr = 32'h400;
    @(posedge clk); #1;
    bus.gnt = 1'b1;
    @(posedge clk); #1;
    bus.gnt = 1'b0;
    @(negedge clk);
    chk("midrst_wait_stall", 32'(o_stall), 32'd1);
    chk("midrst_wait_req", 32'(bus.req), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(o_stall), 32'd0);
    chk("midrst_req", 32'(bus.req), 32'd0);
    chk("midrst_rdata", o_rdata, 32'd0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rvalid = 1'b1; bus.rdata = 32'h0000_FFFF;
    @(posedge clk); #1;
    bus.rvalid = 1'b0;
    n_val = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_rdata_valid) n_val++;
    end
    chk("midrst_late_rvalid", 32'(n_val), 32'd0);
    @(posedge clk); #1;

    do_access(1, 0, 4'b0001, 1, 32'h001, 32'h0, 0, 1, 32'h0000_AB00, 0,
              32'h000, 4'b0010, 32'h0, 32'h0000_00AB, 0, "lbu_after_rst");

    repeat (2) @(posedge clk);
    chk("sb_outstanding", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
